// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer in front of the shift register.
// Optional completed-word counter on port word_cnt when BIT_SERIALIZER_WORD_CNT_EN is defined.
module bit_serializer #(
    parameter int   DATA_WIDTH = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  stall,
    output logic                  bit_out,
    output logic                  bit_valid,
    output logic                  word_start,
    output logic                  busy
`ifdef BIT_SERIALIZER_WORD_CNT_EN
    ,
    output logic [15:0]           word_cnt
`endif
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LEFT_FULL = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] LEFT_ONE  = CW'(1);

    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]         sh_left_q, sh_left_d;

    logic                  out_bit;
    logic [DATA_WIDTH-1:0] sh_shifted;
    logic                  accept;
    logic                  consume;
    logic                  load;

    // Output end and shift direction are fixed at elaboration time.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign out_bit    = sh_q[DATA_WIDTH-1];
            assign sh_shifted = {sh_q[DATA_WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign out_bit    = sh_q[0];
            assign sh_shifted = {1'b0, sh_q[DATA_WIDTH-1:1]};
        end
    endgenerate

    assign bit_valid  = (sh_left_q != '0);
    assign bit_out    = bit_valid ? out_bit : IDLE_LEVEL;
    assign word_start = bit_valid && (sh_left_q == LEFT_FULL);
    assign in_ready   = !hold_full_q;
    assign busy       = hold_full_q || bit_valid;

    assign accept  = in_valid && in_ready;
    assign consume = bit_valid && !stall;
    // Loading on the last consumed bit keeps back-to-back words gapless.
    assign load    = hold_full_q && ((sh_left_q == '0) || ((sh_left_q == LEFT_ONE) && consume));

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sh_d        = sh_q;
        sh_left_d   = sh_left_q;

        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end

        if (load) begin
            sh_d      = hold_q;
            sh_left_d = LEFT_FULL;
        end else if (consume) begin
            sh_d      = sh_shifted;
            sh_left_d = sh_left_q - LEFT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sh_q        <= '0;
            sh_left_q   <= '0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sh_q        <= sh_d;
            sh_left_q   <= sh_left_d;
        end
    end

`ifdef BIT_SERIALIZER_WORD_CNT_EN
    logic [15:0] word_cnt_q, word_cnt_d;

    always_comb begin
        word_cnt_d = word_cnt_q;
        if ((sh_left_q == LEFT_ONE) && !stall) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: expected bits are queued at each handshake and
// popped as the serializer consumes them; a second instance covers LSB-first order.
module tb_bit_serializer;

    localparam logic IDLE = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       stall;
    logic       bit_out;
    logic       bit_valid;
    logic       word_start;
    logic       busy;
`ifdef BIT_SERIALIZER_WORD_CNT_EN
    logic [15:0] word_cnt;
    logic [15:0] word_cnt_l;
`endif

    logic       in_valid_l;
    logic       in_ready_l;
    logic       bit_out_l;
    logic       bit_valid_l;
    logic       word_start_l;
    logic       busy_l;

    always #5 clk = ~clk;

    bit_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .bit_out(bit_out), .bit_valid(bit_valid), .word_start(word_start),
        .busy(busy)
`ifdef BIT_SERIALIZER_WORD_CNT_EN
        , .word_cnt(word_cnt)
`endif
    );

    bit_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_l), .in_ready(in_ready_l),
        .stall(stall), .bit_out(bit_out_l), .bit_valid(bit_valid_l), .word_start(word_start_l),
        .busy(busy_l)
`ifdef BIT_SERIALIZER_WORD_CNT_EN
        , .word_cnt(word_cnt_l)
`endif
    );

    int total = 0;
    int bad = 0;
    logic [1:0] exp_q[$];          // {word_start, bit}
    int consumed = 0;
    int run = 0;
    int max_run = 0;
    int det_cnt = 0;
    logic [3:0] det_sr = 4'b0;
    logic bv_s, bo_s, ws_s, rdy_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 0), d[7-i]});
    endtask

    // One clock: sample/check at negedge, return just after the next posedge.
    task automatic step();
        logic [1:0] e;
        @(negedge clk);
        bv_s  = bit_valid;
        bo_s  = bit_out;
        ws_s  = word_start;
        rdy_s = in_ready;
        if (bit_valid && !stall) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bit", {31'b0, bit_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("bit", {31'b0, bit_out}, {31'b0, e[0]});
                chk("word_start", {31'b0, word_start}, {31'b0, e[1]});
                consumed++;
                det_sr = {det_sr[2:0], bit_out};
                if (det_sr == 4'b1001) begin
                    det_cnt++;
                    det_sr = 4'b0;
                end
            end
        end else if (!bit_valid) begin
            chk("idle_out", {31'b0, bit_out}, {31'b0, IDLE});
            chk("idle_start", {31'b0, word_start}, 32'd0);
        end
        if (bit_valid) begin
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit keep);
        in_data  = d;
        in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            step();
            if (rdy_s) begin
                push_word(d);
                if (!keep) in_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", {31'b0, rdy_s}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        chk("drain_timeout", exp_q.size(), 32'd0);
        step();
        chk("underrun_valid", {31'b0, bv_s}, 32'd0);
    endtask

    initial begin
        int c0;
        int d0;
        logic [7:0] ld;
        rst = 1'b1;
        in_data = 8'h00;
        in_valid = 1'b0;
        in_valid_l = 1'b0;
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, bit_valid}, 32'd0);
        chk("rst_start", {31'b0, word_start}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out", {31'b0, bit_out}, {31'b0, IDLE});
`ifdef BIT_SERIALIZER_WORD_CNT_EN
        chk("rst_word_cnt", {16'b0, word_cnt}, 32'd0);
`endif
        rst = 1'b0;
        step();

        // Single word with latency check
        send(8'h96, 1'b0);
        step();
        chk("lat_edge1_valid", {31'b0, bv_s}, 32'd0);
        step();
        chk("lat_first_valid", {31'b0, bv_s}, 32'd1);
        chk("lat_first_start", {31'b0, ws_s}, 32'd1);
        drain();
        chk("after_busy", {31'b0, busy}, 32'd0);

        // Back-to-back, contiguous stream and 1001 detector
        max_run = 0;
        d0 = det_cnt;
        det_sr = 4'b0;
        send(8'h90, 1'b1);
        in_data = 8'h09;
        step();
        chk("ready_low_full", {31'b0, rdy_s}, 32'd0);
        send(8'h09, 1'b0);
        drain();
        chk("b2b_run", max_run, 32'd16);
        chk("b2b_detect", det_cnt - d0, 32'd2);

        // Stall after two bits
        send(8'hF0, 1'b0);
        c0 = consumed;
        for (int n = 0; n < 50 && (consumed - c0) < 2; n++) step();
        chk("stall_pre_bits", consumed - c0, 32'd2);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_valid", {31'b0, bv_s}, 32'd1);
            chk("stall_out", {31'b0, bo_s}, {31'b0, exp_q[0][0]});
            chk("stall_start", {31'b0, ws_s}, {31'b0, exp_q[0][1]});
        end
        stall = 1'b0;
        drain();
        chk("stall_total_bits", consumed - c0, 32'd8);

        // Reset mid-word with a held word
        send(8'hAA, 1'b0);
        send(8'h55, 1'b0);
        c0 = consumed;
        for (int n = 0; n < 50 && (consumed - c0) < 3; n++) step();
        chk("rst_mid_pre_bits", consumed - c0, 32'd3);
        #1 rst = 1'b1;
        #1;
        chk("rstm_valid", {31'b0, bit_valid}, 32'd0);
        chk("rstm_start", {31'b0, word_start}, 32'd0);
        chk("rstm_busy", {31'b0, busy}, 32'd0);
        chk("rstm_ready", {31'b0, in_ready}, 32'd1);
        chk("rstm_out", {31'b0, bit_out}, {31'b0, IDLE});
        exp_q.delete();
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        for (int n = 0; n < 20; n++) step();
        chk("post_rst_quiet_busy", {31'b0, busy}, 32'd0);
        send(8'h3C, 1'b0);
        drain();

        // LSB-first instance, idle level 1
        ld = 8'h01;
        in_data = ld;
        in_valid_l = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready_l) break;
        end
        @(posedge clk);
        #1;
        in_valid_l = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bit_valid_l) break;
        end
        for (int i = 0; i < 8; i++) begin
            if (i != 0) @(negedge clk);
            chk("lsb_valid", {31'b0, bit_valid_l}, 32'd1);
            chk("lsb_bit", {31'b0, bit_out_l}, {31'b0, ld[i]});
            chk("lsb_start", {31'b0, word_start_l}, {31'b0, (i == 0)});
        end
        @(negedge clk);
        chk("lsb_after_valid", {31'b0, bit_valid_l}, 32'd0);
        chk("lsb_after_idle", {31'b0, bit_out_l}, 32'd1);
        @(posedge clk);
        #1;

`ifdef BIT_SERIALIZER_WORD_CNT_EN
        force dut.word_cnt_q = 16'hFFFE;
        #1;
        release dut.word_cnt_q;
        send(8'h11, 1'b0);
        drain();
        chk("word_cnt_ffff", {16'b0, word_cnt}, 32'h0000FFFF);
        send(8'h22, 1'b0);
        drain();
        chk("word_cnt_wrap", {16'b0, word_cnt}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
